// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic MAC array.
// Modes, controller states and accumulator init values.
package systolic_pkg;

  typedef enum logic [1:0] {
    MODE_MOD  = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_MAXP = 2'd2,
    MODE_MINP = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam int MAX_ACC_W = 64;

  // min-plus starts from +inf (all ones); the others start from zero
  function automatic logic [MAX_ACC_W-1:0] init_val(
    input mode_t m,
    input int    acc_w
  );
    logic [MAX_ACC_W-1:0] v;
    v = '0;
    if (m == MODE_MINP)
      for (int b = 0; b < MAX_ACC_W; b++)
        if (b < acc_w) v[b] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One grid point: forwards a/tag east and b south on each step,
// and folds a,b into its stationary accumulator when tagged.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             init,
  input  mode_t            mode,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  input  logic             tag_in,
  output logic [W-1:0]     a_out,
  output logic [W-1:0]     b_out,
  output logic             tag_out,
  output logic [ACC_W-1:0] acc
);

  logic [W-1:0]     a_q, b_q;
  logic             tag_q;
  logic [ACC_W-1:0] acc_q, acc_d, init_v, ps_ext;
  logic [2*W-1:0]   prod;
  logic [W:0]       psum;
  logic [ACC_W:0]   mac;

  assign init_v = ACC_W'(init_val(mode, ACC_W));
  assign prod   = {{W{1'b0}}, a_in} * {{W{1'b0}}, b_in};
  assign psum   = {1'b0, a_in} + {1'b0, b_in};
  assign ps_ext = ACC_W'(psum);
  assign mac    = {1'b0, acc_q} + (ACC_W+1)'(prod);

  always_comb begin
    acc_d = acc_q;
    unique case (mode)
      MODE_MOD:  acc_d = mac[ACC_W-1:0];
      MODE_SAT:  acc_d = mac[ACC_W] ? '1 : mac[ACC_W-1:0];
      MODE_MAXP: acc_d = (ps_ext > acc_q) ? ps_ext : acc_q;
      MODE_MINP: acc_d = (ps_ext < acc_q) ? ps_ext : acc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= 1'b0;
      acc_q <= '0;
    end else if (init) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= 1'b0;
      acc_q <= init_v;
    end else if (step) begin
      a_q   <= a_in;
      b_q   <= b_in;
      tag_q <= tag_in;
      if (tag_in) acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign tag_out = tag_q;
  assign acc     = acc_q;

endmodule

// File: rtl/systolic_mac_array.sv
// N x N output-stationary systolic array: operand skew, job FSM
// (load, flush, row drain) and the drain row mux.
module systolic_mac_array
  import systolic_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 4,
  parameter int ACC_W = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [7:0]              k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*W-1:0]          a_col,
  input  logic [N*W-1:0]          b_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*ACC_W-1:0]      out_row,
  output logic [((N>1)?$clog2(N):1)-1:0] out_idx,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = (N > 1) ? $clog2(2*N) : 1;
  localparam logic [FW-1:0] FL_LAST  = FW'((N > 1) ? 2*N-3 : 0);
  localparam logic [IW-1:0] ROW_LAST = IW'(N-1);

  state_t        state_q, state_d;
  mode_t         mode_q;
  logic [7:0]    klen_q, kcnt_q;
  logic [FW-1:0] fcnt_q;
  logic [IW-1:0] row_q;
  logic          done_q;
  logic          go, feed, step, last_k, last_f, row_acc, last_row;

  logic [W-1:0]     a_h [N][N+1];
  logic             t_h [N][N+1];
  logic [W-1:0]     b_v [N+1][N];
  logic [ACC_W-1:0] acc [N][N];

  assign go       = (state_q == S_IDLE) && start && (k_len != 8'd0);
  assign feed     = (state_q == S_FEED);
  assign step     = feed ? in_valid : (state_q == S_FLUSH);
  assign last_k   = feed && in_valid && (kcnt_q + 8'd1 == klen_q);
  assign last_f   = (fcnt_q == FL_LAST);
  assign row_acc  = (state_q == S_DRAIN) && out_ready;
  assign last_row = (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go) state_d = S_FEED;
      S_FEED:  if (last_k) state_d = (N > 1) ? S_FLUSH : S_DRAIN;
      S_FLUSH: if (last_f) state_d = S_DRAIN;
      S_DRAIN: if (row_acc && last_row) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_MOD;
      klen_q  <= '0;
      kcnt_q  <= '0;
      fcnt_q  <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= row_acc && last_row;
      if (go) begin
        mode_q <= mode_t'(mode);
        klen_q <= k_len;
        kcnt_q <= '0;
        fcnt_q <= '0;
        row_q  <= '0;
      end
      if (feed && in_valid) kcnt_q <= kcnt_q + 8'd1;
      if (state_q == S_FLUSH) fcnt_q <= fcnt_q + FW'(1);
      if (row_acc) row_q <= last_row ? '0 : row_q + IW'(1);
    end
  end

  // row i of a (with its tag) is delayed by i steps before the west edge
  for (genvar i = 0; i < N; i++) begin : g_row
    logic [W-1:0] a_src;
    assign a_src = feed ? a_col[i*W +: W] : '0;
    if (i == 0) begin : g_direct
      assign a_h[i][0] = a_src;
      assign t_h[i][0] = feed;
    end else begin : g_skew
      logic [W-1:0] sr [i];
      logic         tr [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || init_any(go)) begin
          for (int k = 0; k < i; k++) begin
            sr[k] <= '0;
            tr[k] <= 1'b0;
          end
        end else if (step) begin
          sr[0] <= a_src;
          tr[0] <= feed;
          for (int k = 1; k < i; k++) begin
            sr[k] <= sr[k-1];
            tr[k] <= tr[k-1];
          end
        end
      end
      assign a_h[i][0] = sr[i-1];
      assign t_h[i][0] = tr[i-1];
    end
  end

  for (genvar j = 0; j < N; j++) begin : g_col
    logic [W-1:0] b_src;
    assign b_src = feed ? b_row[j*W +: W] : '0;
    if (j == 0) begin : g_direct
      assign b_v[0][j] = b_src;
    end else begin : g_skew
      logic [W-1:0] sr [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || init_any(go)) begin
          for (int k = 0; k < j; k++) sr[k] <= '0;
        end else if (step) begin
          sr[0] <= b_src;
          for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
        end
      end
      assign b_v[0][j] = sr[j-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pe_r
    for (genvar j = 0; j < N; j++) begin : g_pe_c
      systolic_pe #(.W(W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .init    (go),
        .mode    (go ? mode_t'(mode) : mode_q),
        .a_in    (a_h[i][j]),
        .b_in    (b_v[i][j]),
        .tag_in  (t_h[i][j]),
        .a_out   (a_h[i][j+1]),
        .b_out   (b_v[i+1][j]),
        .tag_out (t_h[i][j+1]),
        .acc     (acc[i][j])
      );
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == S_DRAIN)
      for (int j = 0; j < N; j++)
        out_row[j*ACC_W +: ACC_W] = acc[row_q][j];
  end

  assign in_ready  = feed;
  assign out_valid = (state_q == S_DRAIN);
  assign out_idx   = row_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  function automatic logic init_any(input logic g);
    return g;
  endfunction

endmodule
